// File: rtl/jpeg_stream_feeder.sv
// Byte-to-word packer feeding a JPEG decoder through a 4-entry show-ahead FIFO.
// Packs bytes big-endian, zero-pads the final partial word and sequences one file at a time.
module jpeg_stream_feeder (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ByteIn,
    input  logic        ByteInValid,
    input  logic        ByteInLast,
    output logic        ByteInReady,
    input  logic        Abort,
    output logic [31:0] DataOut,
    output logic        DataOutEnable,
    input  logic        DataOutRead,
    output logic        Busy,
    output logic [15:0] WordCount
);

    // state | meaning
    // IDLE  | no file in progress, FIFO empty
    // LOAD  | accepting bytes of the current file
    // DRAIN | last byte seen, input blocked until the FIFO empties
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t      state_q;
    logic [31:0] mem_q [4];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  count_q, count_d;
    logic [1:0]  byte_cnt_q;
    logic [23:0] acc_q;
    logic [15:0] word_cnt_q, word_cnt_d, word_cnt_base;
    logic [31:0] push_word;
    logic        fifo_full, fifo_empty, transfer, push, pop;

    assign fifo_full     = (count_q == 3'd4);
    assign fifo_empty    = (count_q == 3'd0);
    assign ByteInReady   = !fifo_full && (state_q != DRAIN);
    assign transfer      = ByteInValid && ByteInReady && !Abort;
    assign push          = transfer && ((byte_cnt_q == 2'd3) || ByteInLast);
    assign pop           = DataOutRead && !fifo_empty && !Abort;
    assign count_d       = count_q + {2'b00, push} - {2'b00, pop};
    assign DataOut       = fifo_empty ? 32'h0 : mem_q[rd_ptr_q];
    assign DataOutEnable = !fifo_empty;
    assign Busy          = (state_q != IDLE);
    assign WordCount     = word_cnt_q;

    // Unfilled low bytes stay zero, which also gives the padding of a short last word.
    always_comb begin
        push_word = 32'h0;
        case (byte_cnt_q)
            2'd0:    push_word = {ByteIn, 24'h0};
            2'd1:    push_word = {acc_q[23:16], ByteIn, 16'h0};
            2'd2:    push_word = {acc_q[23:8], ByteIn, 8'h0};
            default: push_word = {acc_q, ByteIn};
        endcase
    end

    always_comb begin
        word_cnt_base = (state_q == IDLE && transfer) ? 16'h0 : word_cnt_q;
        word_cnt_d    = word_cnt_base;
        if (push && word_cnt_base != 16'hFFFF)
            word_cnt_d = word_cnt_base + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            byte_cnt_q <= 2'd0;
            acc_q      <= 24'h0;
            word_cnt_q <= 16'h0;
            for (int i = 0; i < 4; i++)
                mem_q[i] <= 32'h0;
        end else if (Abort) begin
            state_q    <= IDLE;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            byte_cnt_q <= 2'd0;
        end else begin
            case (state_q)
                IDLE:    if (transfer) state_q <= ByteInLast ? DRAIN : LOAD;
                LOAD:    if (transfer && ByteInLast) state_q <= DRAIN;
                DRAIN:   if (count_d == 3'd0) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (transfer) begin
                byte_cnt_q <= push ? 2'd0 : byte_cnt_q + 2'd1;
                acc_q      <= push_word[31:8];
            end
            if (push) begin
                mem_q[wr_ptr_q] <= push_word;
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q    <= count_d;
            word_cnt_q <= word_cnt_d;
        end
    end

endmodule

// File: tb/tb_jpeg_stream_feeder.sv
// Directed bench for jpeg_stream_feeder: vector table plus multi-cycle sequences.
module tb_jpeg_stream_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ByteIn;
    logic        ByteInValid, ByteInLast, Abort, DataOutRead;
    logic        ByteInReady, DataOutEnable, Busy;
    logic [31:0] DataOut;
    logic [15:0] WordCount;

    int n_checks = 0;
    int n_fail   = 0;

    jpeg_stream_feeder dut (
        .clk(clk), .rst(rst), .ByteIn(ByteIn), .ByteInValid(ByteInValid),
        .ByteInLast(ByteInLast), .ByteInReady(ByteInReady), .Abort(Abort),
        .DataOut(DataOut), .DataOutEnable(DataOutEnable), .DataOutRead(DataOutRead),
        .Busy(Busy), .WordCount(WordCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v, l;
        logic [7:0]  b;
        logic        rd;
        logic        e_rdy, e_en;
        logic [31:0] e_data;
        logic [15:0] e_wc;
        logic        e_busy;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(logic v, logic l, logic [7:0] b, logic rd, logic e_rdy,
                                logic e_en, logic [31:0] e_data, logic [15:0] e_wc, logic e_busy);
        vec_t t;
        t.v = v; t.l = l; t.b = b; t.rd = rd; t.e_rdy = e_rdy; t.e_en = e_en;
        t.e_data = e_data; t.e_wc = e_wc; t.e_busy = e_busy;
        return t;
    endfunction

    function automatic logic [31:0] word_of(int w);
        logic [7:0] b0, b1, b2, b3;
        b0 = 8'(4 * w); b1 = 8'(4 * w + 1); b2 = 8'(4 * w + 2); b3 = 8'(4 * w + 3);
        return {b0, b1, b2, b3};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string name, input logic rdy, input logic en,
                              input logic [31:0] data, input logic [15:0] wc, input logic busy);
        n_checks++;
        if (ByteInReady !== rdy || DataOutEnable !== en || DataOut !== data ||
            WordCount !== wc || Busy !== busy) begin
            n_fail++;
            $display("FAIL %s: got rdy=%b en=%b data=%h wc=%0d busy=%b expected rdy=%b en=%b data=%h wc=%0d busy=%b",
                     name, ByteInReady, DataOutEnable, DataOut, WordCount, Busy,
                     rdy, en, data, wc, busy);
        end
    endtask

    task automatic drive(input logic v, input logic l, input logic [7:0] b,
                         input logic rd, input logic ab);
        ByteInValid = v; ByteInLast = l; ByteIn = b; DataOutRead = rd; Abort = ab;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc, k;
        logic rdy_before;

        vecs[0]  = mk(1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 32'h0,        16'd0, 1'b1);
        vecs[1]  = mk(1'b1, 1'b0, 8'hD8, 1'b0, 1'b1, 1'b0, 32'h0,        16'd0, 1'b1);
        vecs[2]  = mk(1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 32'h0,        16'd0, 1'b1);
        vecs[3]  = mk(1'b1, 1'b0, 8'hE0, 1'b0, 1'b1, 1'b1, 32'hFFD8FFE0, 16'd1, 1'b1);
        vecs[4]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0,        16'd1, 1'b1);
        vecs[5]  = mk(1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 32'h11000000, 16'd2, 1'b1);
        vecs[6]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0,        16'd2, 1'b0);
        vecs[7]  = mk(1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 32'h0,        16'd0, 1'b1);
        vecs[8]  = mk(1'b1, 1'b0, 8'h02, 1'b0, 1'b1, 1'b0, 32'h0,        16'd0, 1'b1);
        vecs[9]  = mk(1'b1, 1'b0, 8'h03, 1'b0, 1'b1, 1'b0, 32'h0,        16'd0, 1'b1);
        vecs[10] = mk(1'b1, 1'b0, 8'h04, 1'b0, 1'b1, 1'b1, 32'h01020304, 16'd1, 1'b1);
        vecs[11] = mk(1'b1, 1'b0, 8'h05, 1'b0, 1'b1, 1'b1, 32'h01020304, 16'd1, 1'b1);
        vecs[12] = mk(1'b1, 1'b1, 8'h06, 1'b0, 1'b0, 1'b1, 32'h01020304, 16'd2, 1'b1);
        vecs[13] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h05060000, 16'd2, 1'b1);
        vecs[14] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0,        16'd2, 1'b0);
        vecs[15] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0,        16'd2, 1'b0);
        vecs[16] = mk(1'b1, 1'b1, 8'hAB, 1'b0, 1'b0, 1'b1, 32'hAB000000, 16'd1, 1'b1);
        vecs[17] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0,        16'd1, 1'b0);

        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #12;
        check_outs("reset_state", 1'b1, 1'b0, 32'h0, 16'd0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].v, vecs[i].l, vecs[i].b, vecs[i].rd, 1'b0);
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_en,
                       vecs[i].e_data, vecs[i].e_wc, vecs[i].e_busy);
        end

        // Backpressure: hold each byte until the DUT takes it.
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, 1'b0, 8'(acc), 1'b0, 1'b0);
            rdy_before = ByteInReady;
            step();
            if (rdy_before) begin
                acc++;
                if (acc == 16) check("bp_ready_after_16", {31'd0, ByteInReady}, 32'd0);
            end
        end
        check("bp_accepted", acc, 32'd16);
        check_outs("bp_full", 1'b0, 1'b1, word_of(0), 16'd4, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step();
        check_outs("bp_after_pop", 1'b1, 1'b1, word_of(1), 16'd4, 1'b1);
        for (int b = 16; b < 20; b++) begin
            drive(1'b1, b == 19, 8'(b), 1'b0, 1'b0);
            step();
        end
        check_outs("bp_refill_drain", 1'b0, 1'b1, word_of(1), 16'd5, 1'b1);
        for (int w = 1; w < 5; w++) begin
            check($sformatf("bp_word%0d", w), DataOut, word_of(w));
            drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            step();
        end
        check_outs("bp_empty_idle", 1'b1, 1'b0, 32'h0, 16'd5, 1'b0);

        // Concurrent push and pop: read held high, ten words through the FIFO.
        k = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, i == 39, 8'(i), 1'b1, 1'b0);
            step();
            check($sformatf("cc_en%0d", i), {31'd0, DataOutEnable}, {31'd0, (i % 4) == 3});
            if (DataOutEnable) begin
                check($sformatf("cc_word%0d", k), DataOut, word_of(k));
                k++;
            end
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step();
        check("cc_words_seen", k, 32'd10);
        check_outs("cc_end", 1'b1, 1'b0, 32'h0, 16'd10, 1'b0);

        // Abort with a buffered word and two pending bytes.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 8'hB0 + 8'(i), 1'b0, 1'b0);
            step();
        end
        check_outs("ab_before", 1'b1, 1'b1, 32'hB0B1B2B3, 16'd1, 1'b1);
        drive(1'b1, 1'b0, 8'h77, 1'b0, 1'b1);
        step();
        check_outs("ab_flush", 1'b1, 1'b0, 32'h0, 16'd1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 8'hA1 + 8'(i), 1'b0, 1'b0);
            step();
        end
        check_outs("ab_next_file", 1'b1, 1'b1, 32'hA1A2A3A4, 16'd1, 1'b1);

        // Reset mid-file with three words buffered.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 8'hC0 + 8'(i), 1'b0, 1'b0);
            step();
        end
        check_outs("rst_before", 1'b1, 1'b1, 32'hA1A2A3A4, 16'd3, 1'b1);
        drive(1'b1, 1'b0, 8'h55, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        check_outs("rst_async", 1'b1, 1'b0, 32'h0, 16'd0, 1'b0);
        step();
        check_outs("rst_held", 1'b1, 1'b0, 32'h0, 16'd0, 1'b0);
        rst = 1'b1;
        drive(1'b1, 1'b1, 8'h9A, 1'b0, 1'b0);
        step();
        check_outs("rst_first_xfer", 1'b0, 1'b1, 32'h9A000000, 16'd1, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step();
        check_outs("rst_final_idle", 1'b1, 1'b0, 32'h0, 16'd1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/jpeg_stream_feeder.md
JPEG_STREAM_FEEDER -- requirements
Module: jpeg_stream_feeder

Interface
REQ-001 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port ByteIn, input, 8 bits: JPEG file byte from the host side.
REQ-004 SHALL have port ByteInValid, input, 1 bit: ByteIn is valid this cycle.
REQ-005 SHALL have port ByteInLast, input, 1 bit: the byte on ByteIn is the last byte of the file; qualified by ByteInValid.
REQ-006 SHALL have port ByteInReady, output, 1 bit: the feeder accepts a byte this cycle.
REQ-007 SHALL have port Abort, input, 1 bit: synchronous flush of all buffered data.
REQ-008 SHALL have port DataOut, output, 32 bits: head word presented to the decoder DataIn.
REQ-009 SHALL have port DataOutEnable, output, 1 bit: DataOut is valid; drives decoder DataInEnable.
REQ-010 SHALL have port DataOutRead, input, 1 bit: decoder DataInRead; pops the head word.
REQ-011 SHALL have port Busy, output, 1 bit: the FSM is not in IDLE.
REQ-012 SHALL have port WordCount, output, 16 bits: words pushed for the current file.

Function
REQ-013 SHALL accept a byte only when ByteInValid=1 and ByteInReady=1 (transfer).
REQ-014 SHALL drive ByteInReady = !FifoFull, registered-state based with no combinational path from any input.
REQ-015 SHALL pack bytes big-endian: the 1st byte of a word goes to [31:24], the 2nd to [23:16], the 3rd to [15:8], and the 4th to [7:0].
REQ-016 SHALL keep a 2-bit byte counter ByteCnt; on the 4th byte transfer it SHALL push the completed word into the FIFO in the same edge and reset ByteCnt to 0.
REQ-017 SHALL, on a transfer with ByteInLast=1 and ByteCnt<3, push the partial word with unfilled low bytes padded with 8'h00, and reset ByteCnt to 0.
REQ-018 SHALL implement a 4-entry show-ahead FIFO.
REQ-019 SHALL present the FIFO head on DataOut with DataOutEnable = !FifoEmpty.
REQ-020 SHALL pop the FIFO on the edge where DataOutRead=1 and DataOutEnable=1; DataOutRead while empty SHALL be ignored with no underflow and no pointer change.
REQ-021 SHALL, on simultaneous push and pop, leave the FIFO occupancy unchanged with pointers wrapping modulo 4; a push into a full FIFO SHALL never occur.
REQ-022 SHALL hold DataOut stable while DataOutEnable=1 and no pop occurs.
REQ-023 SHALL implement FSM states IDLE, LOAD and DRAIN.
REQ-024 SHALL transition IDLE->LOAD on the first transfer.
REQ-025 SHALL transition LOAD->DRAIN on a transfer with ByteInLast=1; if that same first transfer has ByteInLast=1, IDLE->DRAIN directly.
REQ-026 SHALL transition DRAIN->IDLE when the FIFO is empty after the edge, including a pop that empties it.
REQ-027 SHALL force ByteInReady=0 in DRAIN, so no bytes of the next file mix with the current one.
REQ-028 SHALL clear WordCount to 0 on IDLE->LOAD (or IDLE->DRAIN), then count it together with the first push when that push occurs in the same cycle.
REQ-029 SHALL increment WordCount by 1 on every push and saturate it at 16'hFFFF.
REQ-030 SHALL make Abort=1 take priority over all other events: FIFO emptied, ByteCnt=0, FSM->IDLE, and the byte offered that cycle not accepted; WordCount SHALL be held.
REQ-031 SHALL drive Busy = (state != IDLE).

Reset
REQ-032 SHALL, with rst=0, asynchronously set: FSM=IDLE, FIFO empty (pointers 0), ByteCnt=0, WordCount=0, DataOut=32'h0, DataOutEnable=0, Busy=0, ByteInReady=1.
REQ-033 SHALL sample no inputs while rst=0; reset asserted mid-file SHALL discard all partial and buffered data.
REQ-034 SHALL deassert rst synchronously to clk externally; the first transfer SHALL be possible on the first edge after release.

Verification
REQ-035 SHALL verify basic packing: bytes FF D8 FF E0 with DataOutRead=0 -> one cycle later DataOut=32'hFFD8FFE0, DataOutEnable=1, WordCount=1, Busy=1.
REQ-036 SHALL verify last-byte padding: 6 bytes 01..06 with ByteInLast on 06 -> words 32'h01020304 and 32'h05060000, state DRAIN, then IDLE after both are popped.
REQ-037 SHALL verify backpressure: 20 bytes streamed with DataOutRead=0 -> ByteInReady=0 after the 16th byte, exactly 4 words buffered, no loss; on a single pop, ByteInReady returns to 1 next cycle.
REQ-038 SHALL verify concurrent push and pop: continuous bytes with DataOutRead held 1 -> occupancy stays at or below 1 word, word order preserved, pointers wrap past 3 without error.
REQ-039 SHALL verify Abort mid-word: 2 bytes accepted, then Abort=1 with ByteInValid=1 -> FIFO empty, ByteCnt=0, IDLE, byte not accepted, WordCount unchanged.
REQ-040 SHALL verify reset mid-file: 3 words buffered, then rst=0 pulse -> all outputs at reset values immediately, without waiting for a clk edge.
